mult_arbiter_2ch: RTL and testbench

MULT_ARBITER_2CH -- requirements
Module: mult_arbiter_2ch

---
 rtl/mult_arb_pkg.sv | 13 +
 rtl/mult_arbiter_2ch_shift_add_core.sv | 55 +++++
 rtl/mult_arbiter_2ch.sv | 123 ++++++++++++
 tb/tb_mult_arbiter_2ch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-channel multiplier arbiter: FSM state
// encoding and the default operand width.
package mult_arb_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_2ch_shift_add_core.sv
// Sequential shift-and-add multiplier datapath. The parent pulses load once
// to capture operands and clear the accumulator, then asserts step once per
// multiplier bit (LSB first). The product is exact in 2*WIDTH bits.
module shift_add_core
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Next-state: load captures operands, step adds the shifted multiplicand for a set bit.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Datapath registers; reset clears everything so the product reads zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/mult_arbiter_2ch.sv
// Two-requester round-robin arbiter in front of a single shift-add multiplier.
// One operation is in flight at a time: IDLE grants and loads, CALC steps the
// core for WIDTH cycles, DONE holds the product until the consumer takes it.
module mult_arbiter_2ch
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             grant;
  logic             accept;
  logic             load, step;
  logic [WIDTH-1:0] op_a, op_b;

  // Grant choice: a lone valid requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign op_a       = grant ? req1_a : req0_a;
  assign op_b       = grant ? req1_b : req0_b;

  // FSM next state and core sequencing; the counter wraps to zero when CALC ends.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    load         = 1'b0;
    step         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load         = 1'b1;
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
    end
  end

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .n_rst  (n_rst),
    .load   (load),
    .step   (step),
    .a      (op_a),
    .b      (op_b),
    .product(rsp_data)
  );

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_mult_arbiter_2ch.sv
// Bench for mult_arbiter_2ch: reset table, directed operation table,
// reset-abort sequences, exhaustive operand sweep and randomized traffic
// checked against a round-robin / a*b reference model.
module tb_mult_arbiter_2ch;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk;
  logic          n_rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [PW-1:0] rsp_data;

  int checks   = 0;
  int failures = 0;
  int model_last = 1;

  typedef struct {
    logic          v0, v1;
    logic [W-1:0]  a0, b0, a1, b1;
    int            grant;
    logic [PW-1:0] data;
    int            bp;
  } vec_t;

  typedef struct {
    logic v0, v1, r0, r1;
  } rvec_t;

  vec_t  tbl  [0:8];
  rvec_t rtbl [0:3];

  mult_arbiter_2ch #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration rule: lone requester wins, contention goes to the one not served last.
  function automatic int model_grant(input logic v0, input logic v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    return 1;
  endfunction

  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input int exp_grant, input logic [PW-1:0] exp_data, input int bp);
    int waited;
    int lat;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b0;
    #1;
    waited = 0;
    while (!(req0_ready || req1_ready) && waited < 5) begin
      tick();
      waited++;
    end
    chk("accept_wait", 32'(waited), 32'(0));
    chk("ready0", 32'(req0_ready), 32'(exp_grant == 0));
    chk("ready1", 32'(req1_ready), 32'(exp_grant == 1));
    tick();
    model_last = exp_grant;
    // Disturb the served requester's operands; the in-flight product must not change.
    if (exp_grant == 0) begin
      req0_a = W'($urandom); req0_b = W'($urandom);
    end else begin
      req1_a = W'($urandom); req1_b = W'($urandom);
    end
    #1;
    chk("busy_calc", 32'(busy), 32'(1));
    chk("ready_calc", 32'({req0_ready, req1_ready}), 32'(0));
    lat = 0;
    while (!rsp_valid && lat < 3 * W + 4) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("rsp_id", 32'(rsp_id), 32'(exp_grant));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_data", 32'(rsp_data), 32'(exp_data));
      chk("bp_id", 32'(rsp_id), 32'(exp_grant));
      chk("bp_ready", 32'({req0_ready, req1_ready}), 32'(0));
    end
    $display("op ch=%0d a=%0d b=%0d data=%0d lat=%0d bp=%0d", exp_grant,
             exp_grant ? a1 : a0, exp_grant ? b1 : b0, rsp_data, lat, bp);
    rsp_ready = 1'b1;
    tick();
    chk("released", 32'(rsp_valid), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic          v0, v1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [7:0]    pair;
    logic [PW-1:0] e;
    int            g;
    int            seen;

    rtbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    rtbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rtbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    rtbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};

    tbl[0] = '{1'b1, 1'b1, 4'd11, 4'd10, 4'd3,  4'd5,  0, 8'd110, 0};
    tbl[1] = '{1'b1, 1'b1, 4'd11, 4'd10, 4'd3,  4'd5,  1, 8'd15,  0};
    tbl[2] = '{1'b1, 1'b0, 4'd15, 4'd15, 4'd0,  4'd0,  0, 8'd225, 0};
    tbl[3] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd0,  4'd7,  1, 8'd0,   0};
    tbl[4] = '{1'b1, 1'b1, 4'd2,  4'd3,  4'd4,  4'd5,  0, 8'd6,   0};
    tbl[5] = '{1'b1, 1'b1, 4'd6,  4'd7,  4'd8,  4'd9,  1, 8'd72,  0};
    tbl[6] = '{1'b1, 1'b1, 4'd12, 4'd13, 4'd14, 4'd1,  0, 8'd156, 0};
    tbl[7] = '{1'b1, 1'b1, 4'd0,  4'd9,  4'd15, 4'd14, 1, 8'd210, 0};
    tbl[8] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd1,  4'd15, 1, 8'd15,  10};

    n_rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;

    // Ready outputs follow IDLE rules while held in reset (last_grant = 1).
    #2;
    chk("rst_valid", 32'(rsp_valid), 32'(0));
    chk("rst_id", 32'(rsp_id), 32'(0));
    chk("rst_data", 32'(rsp_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    for (int i = 0; i < 4; i++) begin
      req0_valid = rtbl[i].v0;
      req1_valid = rtbl[i].v1;
      #1;
      chk("rst_ready0", 32'(req0_ready), 32'(rtbl[i].r0));
      chk("rst_ready1", 32'(req1_ready), 32'(rtbl[i].r1));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_rst = 1'b1;
    model_last = 1;

    // Directed table: contention after reset, single requests, alternation, backpressure.
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
             tbl[i].grant, tbl[i].data, tbl[i].bp);
    end

    // Reset two cycles into CALC: outputs clear at once, no response follows.
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
    #1;
    chk("abort_ready1", 32'(req1_ready), 32'(1));
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid), 32'(0));
    chk("abort_data", 32'(rsp_data), 32'(0));
    chk("abort_id", 32'(rsp_id), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    tick();
    n_rst = 1'b1;
    model_last = 1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (rsp_valid || busy) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'(0));
    $display("op abort in CALC ch=1 a=7 b=9");
    run_op(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd9, 1, 8'd63, 0);

    // Reset while the result waits in DONE: the result is discarded.
    req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 4'd13; req0_b = 4'd11;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    chk("done_before_rst", 32'(rsp_valid), 32'(1));
    n_rst = 1'b0;
    #1;
    chk("done_rst_valid", 32'(rsp_valid), 32'(0));
    chk("done_rst_data", 32'(rsp_data), 32'(0));
    tick();
    n_rst = 1'b1;
    model_last = 1;
    $display("op abort in DONE ch=0 a=13 b=11");

    // Exhaustive sweep on alternating requesters.
    for (int i = 0; i < 256; i++) begin
      pair = 8'(i);
      if (i % 2 == 0) begin
        run_op(1'b1, 1'b0, pair[7:4], pair[3:0], W'($urandom), W'($urandom),
               0, PW'(pair[7:4]) * PW'(pair[3:0]), 0);
      end else begin
        run_op(1'b0, 1'b1, W'($urandom), W'($urandom), pair[7:4], pair[3:0],
               1, PW'(pair[7:4]) * PW'(pair[3:0]), 0);
      end
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      g = model_grant(v0, v1, model_last);
      e = (g == 1) ? PW'(a1) * PW'(b1) : PW'(a0) * PW'(b0);
      run_op(v0, v1, a0, b0, a1, b1, g, e, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
